mdio_target: RTL and testbench

Parameterised MDIO management-target controller, successor to the single-mode Clause 22 controller. Sits between the MDIO serial line, sampled on `clk` as MDC, and the PHY register file. Decodes Clause 22 frames and, when compiled in, Clause 45 frames: indirect 16-bit address register, post-increment reads, configurable preamble and PHY address. Write frames produce a one-cycle register write strobe. Read frames request register data and return it in parallel with a completion pulse.

---
 rtl/mdio_target.sv | 177 +++++++++++++++++
 tb/tb_mdio_target.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdio_target.sv
// mdio_target: MDIO management target; Clause 22 always, Clause 45 decode and
// indirect address register only when MDIO_C45_EN is defined.
module mdio_target #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter bit         ACCEPT_BCAST = 1'b1,
  parameter int         PREAMBLE_LEN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  input  logic [15:0] rd_data,
  output logic        mdio_done,
  output logic [15:0] mdio_in,
  output logic [20:0] addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic        frame_err
);
`ifdef MDIO_C45_EN
  localparam bit C45 = 1'b1;
`else
  localparam bit C45 = 1'b0;
`endif
  localparam logic [5:0] PRE_N = 6'(PREAMBLE_LEN);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, HDR = 3'd2, TA = 3'd3,
                         WDATA = 3'd4, RDATA = 3'd5, SKIP = 3'd6;
  logic [2:0]  st_q, st_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [13:0] hdr_q, hdr_d, hs;
  logic [14:0] sh_q, sh_d;
  logic [15:0] areg_q, areg_d, mi_q, mi_d, wd_q, wd_d;
  logic [20:0] addr_q, addr_d, ea;
  logic        done_q, done_d, wr_q, wr_d, rd_q, rd_d, err_q, err_d;
  logic        c22, c45, is_wr, is_addr, is_rd, is_inc, bad, hit;
  // During HDR the decode must include the bit being sampled right now
  assign hs      = (st_q == HDR) ? {hdr_q[12:0], mdio_out} : hdr_q;
  assign c22     = hs[13:12] == 2'b01;
  assign c45     = C45 && hs[13:12] == 2'b00;
  assign is_wr   = (c22 || c45) && hs[11:10] == 2'b01;
  assign is_addr = c45 && hs[11:10] == 2'b00;
  assign is_rd   = (c22 && hs[11:10] == 2'b10) || (c45 && hs[11]);
  assign is_inc  = c45 && hs[11:10] == 2'b10;
  assign bad     = !(is_wr || is_addr || is_rd);
  assign hit     = hs[9:5] == PHY_ADDR || (ACCEPT_BCAST && hs[9:5] == 5'd0 && !is_rd);
  assign ea      = c45 ? {hs[4:0], areg_q} : {16'd0, hs[4:0]};
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    sh_d = sh_q;
    areg_d = areg_q;
    mi_d = mi_q;
    wd_d = wd_q;
    addr_d = addr_q;
    done_d = 1'b0;
    wr_d = 1'b0;
    rd_d = 1'b0;
    err_d = 1'b0;
    case (st_q)
      IDLE: if (mdio_oe) begin
        if (PRE_N == 6'd0) begin
          st_d = HDR;
          hdr_d = {13'd0, mdio_out};
          cnt_d = 6'd1;
        end else begin
          st_d = PRE;
          cnt_d = {5'd0, mdio_out};
        end
      end
      PRE: if (!mdio_oe) begin
        st_d = IDLE;
        cnt_d = 6'd0;
      end else if (mdio_out) begin
        cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
      end else if (cnt_q >= PRE_N) begin
        st_d = HDR;
        hdr_d = 14'd0;
        cnt_d = 6'd1;
      end else begin
        cnt_d = 6'd0;
      end
      HDR: if (!mdio_oe) begin
        st_d = IDLE;
        cnt_d = 6'd0;
        err_d = 1'b1;
      end else begin
        hdr_d = hs;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd13) begin
          st_d = (bad || !hit) ? SKIP : is_rd ? RDATA : TA;
          err_d = bad;
          rd_d = !bad && hit && is_rd;
          addr_d = (!bad && hit && is_rd) ? ea : addr_q;
        end
      end
      TA: begin
        cnt_d = cnt_q + 6'd1;
        st_d = (cnt_q == 6'd15) ? WDATA : TA;
      end
      WDATA: if (!mdio_oe) begin
        st_d = IDLE;
        cnt_d = 6'd0;
        err_d = 1'b1;
      end else begin
        sh_d = {sh_q[13:0], mdio_out};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          st_d = IDLE;
          cnt_d = 6'd0;
          done_d = 1'b1;
          wr_d = !is_addr;
          areg_d = is_addr ? {sh_q, mdio_out} : areg_q;
          wd_d = is_addr ? wd_q : {sh_q, mdio_out};
          addr_d = is_addr ? addr_q : ea;
        end
      end
      RDATA: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd15) begin
          mi_d = rd_data;
          areg_d = is_inc ? areg_q + 16'd1 : areg_q;
        end
        if (cnt_q == 6'd31) begin
          st_d = IDLE;
          cnt_d = 6'd0;
          done_d = 1'b1;
        end
      end
      SKIP: begin
        cnt_d = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        st_d = (cnt_q == 6'd31) ? IDLE : SKIP;
      end
      default: begin
        st_d = IDLE;
        cnt_d = 6'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE;
      cnt_q <= 6'd0;
      hdr_q <= 14'd0;
      sh_q <= 15'd0;
      areg_q <= 16'd0;
      mi_q <= 16'd0;
      wd_q <= 16'd0;
      addr_q <= 21'd0;
      done_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      sh_q <= sh_d;
      areg_q <= areg_d;
      mi_q <= mi_d;
      wd_q <= wd_d;
      addr_q <= addr_d;
      done_q <= done_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  end
  assign mdio_done = done_q;
  assign mdio_in   = mi_q;
  assign addr      = addr_q;
  assign wr_data   = wd_q;
  assign wr_stb    = wr_q;
  assign rd_stb    = rd_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_mdio_target.sv
// tb_mdio_target: scoreboard bench for mdio_target; Clause 45 checks follow MDIO_C45_EN.
module tb_mdio_target;
`ifdef MDIO_C45_EN
  localparam bit C45 = 1'b1;
`else
  localparam bit C45 = 1'b0;
`endif
  localparam logic [3:0] WR = 4'b1000, RD = 4'b0100, DONE = 4'b0010, ERR = 4'b0001;
  typedef struct {
    int          c;
    logic [3:0]  f;
    logic [20:0] a;
    logic [15:0] d;
    logic [15:0] mi;
    bit          mc;
  } ev_t;
  logic        clk = 1'b0, reset = 1'b0, mdio_out = 1'b0, mdio_oe = 1'b0;
  logic        p_out = 1'b0, p_oe = 1'b0;
  logic [15:0] rd_data = 16'h0, rdv = 16'h0;
  logic        mdio_done, wr_stb, rd_stb, frame_err, p_done, p_wr, p_rd, p_err;
  logic [15:0] mdio_in, wr_data, p_mi, p_wdata;
  logic [20:0] addr, p_addr;
  logic [15:0] areg_m = 16'h0, mi_m = 16'h0;
  ev_t         sb[$];
  int          cyc = 0, n_tests = 0, n_fail = 0;
  int          pbase = 0, p_wr_n = 0, p_wr_cyc = 0, p_done_n = 0, p_bad_n = 0;
  logic [20:0] p_a = '0;
  logic [15:0] p_d = '0;
  mdio_target dut (
    .clk(clk), .reset(reset), .mdio_out(mdio_out), .mdio_oe(mdio_oe), .rd_data(rd_data),
    .mdio_done(mdio_done), .mdio_in(mdio_in), .addr(addr), .wr_data(wr_data),
    .wr_stb(wr_stb), .rd_stb(rd_stb), .frame_err(frame_err)
  );
  mdio_target #(.PREAMBLE_LEN(32)) dut_p (
    .clk(clk), .reset(reset), .mdio_out(p_out), .mdio_oe(p_oe), .rd_data(rd_data),
    .mdio_done(p_done), .mdio_in(p_mi), .addr(p_addr), .wr_data(p_wdata),
    .wr_stb(p_wr), .rd_stb(p_rd), .frame_err(p_err)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= rd_stb ? rdv : 16'hDEAD;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int c, input logic [3:0] f, input logic [20:0] a,
                      input logic [15:0] d, input logic [15:0] mi, input bit mc);
    sb.push_back('{c, f, a, d, mi, mc});
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (reset && (wr_stb || rd_stb || mdio_done || frame_err)) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ev_cycle", 64'(cyc), 64'(e.c));
        chk("ev_flags", {60'd0, wr_stb, rd_stb, mdio_done, frame_err}, {60'd0, e.f});
        if (wr_stb || rd_stb) chk("ev_addr", {43'd0, addr}, {43'd0, e.a});
        if (wr_stb) chk("ev_wdata", {48'd0, wr_data}, {48'd0, e.d});
        if (e.mc) chk("ev_mdio_in", {48'd0, mdio_in}, {48'd0, e.mi});
      end
    end
  end
  always @(negedge clk) begin
    if (p_wr) begin
      p_wr_n++;
      p_wr_cyc = cyc;
      p_a = p_addr;
      p_d = p_wdata;
    end
    if (p_done) p_done_n++;
    if (p_rd || p_err) p_bad_n++;
  end
  // Drives one 32-bit frame and queues what the target should produce for it
  task automatic frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] d, input int drop, input int rst_at);
    logic [31:0] w;
    logic        c45, rd, bad, ok;
    logic [20:0] ea;
    int          base;
    c45 = C45 && st == 2'b00;
    rd = (st == 2'b01 && op == 2'b10) || (c45 && op[1]);
    bad = !((st == 2'b01 && op[1] != op[0]) || c45);
    ok = !bad && (phy == 5'd1 || (phy == 5'd0 && !rd));
    ea = c45 ? {ra, areg_m} : {16'd0, ra};
    w = {st, op, phy, ra, 2'b10, d};
    base = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      mdio_oe = (drop < 0 || k < drop) && !(ok && rd && k >= 14);
      mdio_out = w[31-k];
      if (k == 0) begin
        base = cyc;
        if (drop >= 0 && drop < 14) push(base + drop + 1, ERR, '0, '0, '0, 0);
        else if (bad) push(base + 14, ERR, '0, '0, '0, 0);
        else if (ok && rd) begin
          push(base + 14, RD, ea, '0, '0, 0);
          if (rst_at < 0) push(base + 32, DONE, '0, '0, rdv, 1);
        end
        else if (ok && drop >= 16) push(base + drop + 1, ERR, '0, '0, '0, 0);
        else if (ok && c45 && op == 2'b00) push(base + 32, DONE, '0, '0, '0, 0);
        else if (ok) push(base + 32, WR | DONE, ea, d, '0, 0);
      end
      if (ok && rd && rst_at < 0 && k == 15) chk("mdio_in_hold", {48'd0, mdio_in}, {48'd0, mi_m});
      if (ok && rd && rst_at < 0 && k == 16) chk("mdio_in_latch", {48'd0, mdio_in}, {48'd0, rdv});
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        chk("midframe_reset", {7'd0, mdio_done, mdio_in, addr, wr_data, wr_stb, rd_stb, frame_err}, 64'd0);
        sb.delete();
      end
    end
    @(posedge clk);
    #1;
    mdio_oe = 1'b0;
    mdio_out = 1'b0;
    if (rst_at >= 0) begin
      mi_m = '0;
      areg_m = '0;
    end else if (ok && rd) begin
      mi_m = rdv;
      if (c45 && op == 2'b10) areg_m = areg_m + 16'd1;
    end else if (ok && drop < 0 && c45 && op == 2'b00) areg_m = d;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask
  task automatic pframe(input int n);
    logic [31:0] w;
    w = {2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'h1234};
    for (int k = 0; k < n + 32; k++) begin
      @(posedge clk);
      #1;
      p_oe = 1'b1;
      p_out = (k < n) ? 1'b1 : w[31-(k-n)];
      if (k == n) pbase = cyc;
    end
    @(posedge clk);
    #1;
    p_oe = 1'b0;
    p_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {7'd0, mdio_done, mdio_in, addr, wr_data, wr_stb, rd_stb, frame_err}, 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    frame(2'b01, 2'b01, 5'd1, 5'd5, 16'hABCD, -1, -1);
    rdv = 16'hFEED;
    frame(2'b01, 2'b10, 5'd1, 5'd8, 16'h0000, -1, -1);
    chk("wr_data_hold", {48'd0, wr_data}, {48'd0, 16'hABCD});
    frame(2'b01, 2'b01, 5'd3, 5'd5, 16'h1111, -1, -1);
    frame(2'b01, 2'b01, 5'd1, 5'd9, 16'h1357, -1, -1);
    frame(2'b01, 2'b01, 5'd0, 5'd2, 16'h2468, -1, -1);
    rdv = 16'h5555;
    frame(2'b01, 2'b10, 5'd0, 5'd2, 16'h0000, -1, -1);
    chk("mdio_in_hold_ignored", {48'd0, mdio_in}, {48'd0, 16'hFEED});
    frame(2'b10, 2'b01, 5'd1, 5'd4, 16'h0F0F, -1, -1);
    frame(2'b01, 2'b00, 5'd1, 5'd4, 16'h0F0F, -1, -1);
    frame(2'b01, 2'b01, 5'd1, 5'd6, 16'h9999, 20, -1);
    chk("abort_addr_hold", {43'd0, addr}, {43'd0, 21'h2});
    frame(2'b01, 2'b01, 5'd1, 5'd6, 16'h9999, 5, -1);
    frame(2'b00, 2'b00, 5'd1, 5'd1, 16'hFFFF, -1, -1);
    rdv = 16'h0A0A;
    frame(2'b00, 2'b10, 5'd1, 5'd1, 16'h0000, -1, -1);
    rdv = 16'h0B0B;
    frame(2'b00, 2'b10, 5'd1, 5'd1, 16'h0000, -1, -1);
    frame(2'b00, 2'b01, 5'd1, 5'd2, 16'h5A5A, -1, -1);
    frame(2'b00, 2'b00, 5'd1, 5'd1, 16'h7777, 20, -1);
    rdv = 16'h0C0C;
    frame(2'b00, 2'b11, 5'd1, 5'd1, 16'h0000, -1, -1);
    rdv = 16'hC0DE;
    frame(2'b01, 2'b10, 5'd1, 5'd7, 16'h0000, -1, 20);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    frame(2'b01, 2'b01, 5'd1, 5'd31, 16'h8001, -1, -1);
    pframe(31);
    chk("pre31_ignored", 64'(p_wr_n), 64'd0);
    pframe(32);
    chk("pre32_wr_count", 64'(p_wr_n), 64'd1);
    chk("pre32_wr_cycle", 64'(p_wr_cyc), 64'(pbase + 32));
    chk("pre32_addr", {43'd0, p_a}, {43'd0, 21'h3});
    chk("pre32_wdata", {48'd0, p_d}, {48'd0, 16'h1234});
    chk("pre_done_count", 64'(p_done_n), 64'd1);
    chk("pre_no_rd_err", 64'(p_bad_n), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
